ram_bus_master: RTL
===================

// Module: ram_bus_master
// PURPOSE
//  Initiator for the single-port synchronous RAM bus (address / bidirectional data / write / en).
//  Converts burst commands (start address + length) into RAM bus cycles with auto-incrementing address.
//  Drives the shared tri-state data bus only during write cycles.
//  Sits between user logic (cmd / write-stream / read-stream) and the ram instance.
// PARAMETERS
//  WIDTH   8   data width of RAM word and streams
//  A_SIZE  8   address width; RAM depth = 2**A_SIZE
// PORTS
//  clk        in     1       clock, all activity on posedge
//  rst_n      in     1       asynchronous active-low reset
//  cmd_valid  in     1       burst command present
//  cmd_ready  out    1       command accepted when cmd_valid && cmd_ready
//  cmd_write  in     1       1 = write burst, 0 = read burst
//  cmd_addr   in     A_SIZE  first word address
//  cmd_len    in     A_SIZE  beats minus 1 (0 = single word)
//  wr_data    in     WIDTH   write-stream data
//  wr_valid   in     1       write-stream beat present
//  wr_ready   out    1       beat consumed when wr_valid && wr_ready
//  rd_data    out    WIDTH   read-stream data
//  rd_valid   out    1       one-cycle strobe per read beat, no backpressure
//  busy       out    1       state != IDLE
//  mem_addr   out    A_SIZE  RAM address (registered)
//  mem_data   inout  WIDTH   RAM data bus; driven = wdata reg when mem_write=1, else all-Z
//  mem_write  out    1       RAM write strobe (registered)
//  mem_en     out    1       RAM enable (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; mem_en=0, mem_write=0, mem_addr=0, mem_data=Z, rd_valid=0,
//   rd_data=0, wr_ready=0, busy=0, cmd_ready=1 (cmd_ready = state==IDLE). Any burst is abandoned;
//   in-flight reads produce no rd_valid.
//  States: IDLE, WRITE, TURN, READ, DRAIN.
//  IDLE: on cmd accept latch addr, remaining=cmd_len; -> WRITE if cmd_write, else -> READ.
//  WRITE: wr_ready=1. Each accepted beat registers mem_addr=addr, wdata=wr_data, mem_write=1, mem_en=1
//   for exactly one cycle. addr+=1, remaining-=1. wr_valid=0: mem_en=0, mem_write=0, address held,
//   no duplicate write. Last beat (remaining==0) accepted -> TURN.
//  TURN: one cycle, mem_en=0, mem_write=0, bus Z (turnaround) -> IDLE.
//  READ: one read issued per cycle: mem_addr=addr, mem_en=1, mem_write=0. After last issue -> DRAIN.
//  RAM timing: samples addr/en/write at posedge; read data valid on mem_data the cycle after sampling.
//  Read latency: rd_valid/rd_data asserted exactly 2 cycles after the corresponding mem_addr appears;
//   beats delivered back-to-back in address order. Tracked with a 2-stage issue-valid pipe.
//  DRAIN: mem_en=0; stays until issue pipe empty (2 cycles) -> IDLE. cmd_ready low until IDLE.
//  Address arithmetic mod 2**A_SIZE: 0xFF+1 wraps to 0x00 (A_SIZE=8). Burst of cmd_len=2**A_SIZE-1
//   touches every word once.
//  wr_valid outside WRITE ignored; cmd_valid while busy held off by cmd_ready=0.
//  mem_write=1 never coincides with mem_en=0; bus never driven in IDLE, TURN, READ, DRAIN, or reset.
// TESTING (WIDTH=8, A_SIZE=8)
//  1 Reset: rst_n=0 mid-clock -> mem_en=0, mem_write=0, mem_data=Z, busy=0, cmd_ready=1 immediately.
//  2 Write addr=0x10 len=3, wr_data 0xA0..0xA3, wr_valid=1 -> 4 consecutive mem_write cycles
//    addr 0x10..0x13 data 0xA0..0xA3, 1 TURN cycle with bus Z, then cmd_ready=1.
//  3 Read addr=0x10 len=3 -> rd_valid 4 consecutive cycles 0xA0,0xA1,0xA2,0xA3; first rd_valid
//    2 cycles after mem_addr=0x10; cmd_ready=1 the cycle after last rd_valid.
//  4 Wrap: write addr=0xFE len=3 data 1..4 -> mem_addr 0xFE,0xFF,0x00,0x01; read-back returns 1..4.
//  5 Stall: write len=3 with wr_valid=0 for 2 cycles after beat 1 -> mem_en=0 those cycles,
//    mem_addr held, exactly 4 RAM writes total, contents correct on read-back.
//  6 Reset during read addr=0x00 len=15 after 5 issues -> bus Z, no further rd_valid, next
//    read addr=0x10 len=0 after release returns 0xA0.

Source files
------------

// File: rtl/ram_bus_master.sv
// Purpose : burst initiator for a single-port synchronous RAM (addr / tri-state data / write / en).
// Latency : write beat on the RAM bus 1 cycle after handshake; rd_valid 2 cycles after mem_addr is issued.
// Backpres: wr_ready stalls the write stream; the read stream has no backpressure; cmd_ready low while busy.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              burst command handshake (cmd_write, cmd_addr, cmd_len = beats-1)
//   wr_data/wr_valid/wr_ready        write stream into the RAM
//   rd_data/rd_valid                 read stream out of the RAM, one-cycle strobe per beat
//   busy                             controller not idle
//   mem_addr/mem_data/mem_write/mem_en  registered RAM bus; mem_data driven only while mem_write=1
module ram_bus_master #(
    parameter int WIDTH  = 8,
    parameter int A_SIZE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [A_SIZE-1:0] cmd_addr,
    input  logic [A_SIZE-1:0] cmd_len,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [A_SIZE-1:0] mem_addr,
    inout  wire  [WIDTH-1:0]  mem_data,
    output logic              mem_write,
    output logic              mem_en
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        TURN,
        READ,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [A_SIZE-1:0] addr;
    logic [A_SIZE-1:0] remaining;
    logic [WIDTH-1:0]  wdata;
    // Last write beat accepted; WRITE lingers one cycle so that beat is on the bus
    // before TURN releases it.
    logic              wr_done;
    // Issue-valid pipe: stage 1 = address on the bus, stage 2 = RAM data on the bus.
    logic              iss_v1;
    logic              iss_v2;
    logic              beat;
    logic              issue;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign wr_ready  = (state == WRITE) && !wr_done;
    assign beat      = wr_valid && wr_ready;
    assign issue     = (state == READ);

    assign mem_data  = mem_write ? wdata : {WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_write ? WRITE : READ;
            WRITE:   if (wr_done) state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            READ:    if (remaining == '0) state_nxt = DRAIN;
            // Wait until every issued read has come back out of the pipe.
            DRAIN:   if (!iss_v1 && !iss_v2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            wdata     <= '0;
            wr_done   <= 1'b0;
            mem_addr  <= '0;
            mem_write <= 1'b0;
            mem_en    <= 1'b0;
            iss_v1    <= 1'b0;
            iss_v2    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed below; mem_addr holds its value.
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            iss_v1    <= 1'b0;
            iss_v2    <= iss_v1;
            rd_valid  <= iss_v2;
            if (iss_v2) begin
                rd_data <= mem_data;
            end

            if ((state == IDLE) && cmd_valid) begin
                addr      <= cmd_addr;
                remaining <= cmd_len;
                wr_done   <= 1'b0;
            end

            if (beat) begin
                mem_addr  <= addr;
                wdata     <= wr_data;
                mem_write <= 1'b1;
                mem_en    <= 1'b1;
                addr      <= addr + A_SIZE'(1);
                remaining <= remaining - A_SIZE'(1);
                if (remaining == '0) begin
                    wr_done <= 1'b1;
                end
            end

            if (issue) begin
                mem_addr  <= addr;
                mem_en    <= 1'b1;
                iss_v1    <= 1'b1;
                addr      <= addr + A_SIZE'(1);
                remaining <= remaining - A_SIZE'(1);
            end
        end
    end

endmodule
